// File: rtl/dac_slew_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
// Shared types and constants for the SPGD DAC output stage.
//   DAC_WIDTH   : DAC code width (signed two's complement codes)
//   dac_state_e : slew controller FSM states
//   dac_code_t  : signed DAC code
//   dac_diff_t  : one bit wider than a code, so target - out never overflows
//   clamp_code  : saturate a code into [lo, hi]
// ---------------------------------------------------------------------------
package dac_pkg;

  localparam int unsigned DAC_WIDTH = 14;

  typedef enum logic {
    IDLE,
    RAMP
  } dac_state_e;

  typedef logic signed [DAC_WIDTH-1:0] dac_code_t;
  typedef logic signed [DAC_WIDTH:0]   dac_diff_t;

  function automatic dac_code_t clamp_code(input dac_code_t c,
                                           input dac_code_t lo,
                                           input dac_code_t hi);
    dac_code_t r;
    r = c;
    if (c < lo) r = lo;
    if (c > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/dac_slew_ctrl_if.sv
// ---------------------------------------------------------------------------
// dac_slew_ctrl_if
// Code-input handshake and DAC-pin bundle for dac_slew_ctrl.
//   en         : output enable (low drives the target to 0)
//   code_in    : signed target code from the converter
//   code_valid : code_in valid this cycle
//   code_ready : slew stage accepts code_in (registered copy of en)
//   dac_data   : code presented to the DAC pins
//   dac_we     : one-cycle write strobe, dac_data changed this cycle
//   settled    : output equals target, no ramp pending
// Modports: master = converter / pin consumer side, slave = slew controller.
// ---------------------------------------------------------------------------
interface dac_slew_ctrl_if;
  import dac_pkg::*;

  logic                 en;
  dac_code_t            code_in;
  logic                 code_valid;
  logic                 code_ready;
  logic [DAC_WIDTH-1:0] dac_data;
  logic                 dac_we;
  logic                 settled;

  modport master (
    output en, code_in, code_valid,
    input  code_ready, dac_data, dac_we, settled
  );

  modport slave (
    input  en, code_in, code_valid,
    output code_ready, dac_data, dac_we, settled
  );

endinterface

// File: rtl/dac_tick_gen.sv
// ---------------------------------------------------------------------------
// dac_tick_gen
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// The tick is high in the cycle where the counter equals TICK_DIV-1; the
// counter then wraps to 0. Counter clears on synchronous active-low reset.
// Parameters: TICK_DIV (>= 2) clock cycles per tick.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   tick  : one-cycle update tick
// ---------------------------------------------------------------------------
module dac_tick_gen #(
  parameter int unsigned TICK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_slew_ctrl.sv
// ---------------------------------------------------------------------------
// dac_slew_ctrl
// Output stage after the voltage-to-DAC-code converter in the SPGD loop.
// Accepts signed codes over a valid/ready handshake, clamps them to
// [CODE_MIN, CODE_MAX], and ramps the DAC output toward the target by at
// most MAX_STEP per update tick, strobing dac_we on every output change.
//
// Parameters:
//   MAX_STEP : max absolute code change per tick (1 .. 2^(DAC_WIDTH-1))
//   TICK_DIV : clock cycles per update tick (>= 2)
//   CODE_MIN : lowest allowed target code (<= 0)
//   CODE_MAX : highest allowed target code (>= 0)
// Ports:
//   clk   : system clock, all logic on rising edge
//   rst_n : synchronous active-low reset
//   bus   : dac_slew_ctrl_if.slave (en, code_in, code_valid, code_ready,
//           dac_data, dac_we, settled)
// Build option:
//   DAC_OFFSET_BINARY_EN : dac_data is offset binary (MSB inverted);
//                          otherwise two's complement.
// ---------------------------------------------------------------------------
module dac_slew_ctrl
  import dac_pkg::*;
#(
  parameter int unsigned MAX_STEP = 64,
  parameter int unsigned TICK_DIV = 125,
  parameter int          CODE_MIN = -8192,
  parameter int          CODE_MAX = 8191
) (
  input  logic          clk,
  input  logic          rst_n,
  dac_slew_ctrl_if.slave bus
);

  localparam dac_code_t CMIN = dac_code_t'(CODE_MIN);
  localparam dac_code_t CMAX = dac_code_t'(CODE_MAX);
  localparam dac_diff_t STEP = dac_diff_t'(MAX_STEP);

  dac_state_e state_q, state_d;
  dac_code_t  target_q, target_d;
  dac_code_t  out_q, out_d;
  dac_diff_t  diff;
  logic       ready_q;
  logic       we_q, we_d;
  logic       tick;
  logic       accept;

  dac_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign accept = bus.code_valid && ready_q;

  // Disable overrides any accept in the same cycle.
  always_comb begin
    target_d = target_q;
    if (!bus.en) begin
      target_d = '0;
    end else if (accept) begin
      target_d = clamp_code(bus.code_in, CMIN, CMAX);
    end
  end

  // Steps use target_q, so an accept coinciding with a tick only takes
  // effect from the following tick. The leave-RAMP decision compares the
  // next target with the next output so a same-cycle retarget keeps the
  // FSM consistent with settled.
  always_comb begin
    diff    = dac_diff_t'(target_q) - dac_diff_t'(out_q);
    out_d   = out_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (target_d != out_q) state_d = RAMP;
      end
      RAMP: begin
        if (tick) begin
          if ((diff <= STEP) && (diff >= -STEP)) begin
            out_d = target_q;
          end else if (diff > 0) begin
            out_d = dac_code_t'(dac_diff_t'(out_q) + STEP);
          end else begin
            out_d = dac_code_t'(dac_diff_t'(out_q) - STEP);
          end
        end
        state_d = (target_d != out_d) ? RAMP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    we_d = (out_d != out_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      out_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      out_q    <= out_d;
      ready_q  <= bus.en;
      we_q     <= we_d;
    end
  end

  assign bus.code_ready = ready_q;
  assign bus.dac_we     = we_q;
  assign bus.settled    = (state_q == IDLE);

`ifdef DAC_OFFSET_BINARY_EN
  assign bus.dac_data = {~out_q[DAC_WIDTH-1], out_q[DAC_WIDTH-2:0]};
`else
  assign bus.dac_data = out_q;
`endif

endmodule

// File: tb/tb_dac_slew_ctrl.sv
module tb_dac_slew_ctrl;
  import dac_pkg::*;

  localparam int TB_MAX_STEP = 64;
  localparam int TB_TICK_DIV = 4;
  localparam int TB_CODE_MIN = -8192;
  localparam int TB_CODE_MAX = 4000;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DAC_WIDTH-1:0] RST_RAW = 14'h2000;
`else
  localparam logic [DAC_WIDTH-1:0] RST_RAW = 14'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dac_slew_ctrl_if bus();

  dac_slew_ctrl #(
    .MAX_STEP(TB_MAX_STEP),
    .TICK_DIV(TB_TICK_DIV),
    .CODE_MIN(TB_CODE_MIN),
    .CODE_MAX(TB_CODE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference: target, output and tick phase as plain integers.
  int m_target, m_out, m_cnt, m_ready, m_we;

  int strobes[$];
  bit gaps_ok, settle_ok, timed_out;

  function automatic int dac_val();
    logic [DAC_WIDTH-1:0] r;
    r = bus.dac_data;
`ifdef DAC_OFFSET_BINARY_EN
    r[DAC_WIDTH-1] = ~r[DAC_WIDTH-1];
`endif
    return int'($signed(r));
  endfunction

  // One clock: update the reference from the inputs seen at the edge,
  // then move 1 time unit past the edge for sampling and driving.
  task automatic clk_step();
    int d, c;
    bit tk;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_target = 0; m_out = 0; m_cnt = 0; m_ready = 0; m_we = 0;
    end else begin
      tk    = (m_cnt == TB_TICK_DIV - 1);
      m_cnt = (m_cnt + 1) % TB_TICK_DIV;
      m_we  = 0;
      if (tk && (m_out != m_target)) begin
        d = m_target - m_out;
        if (d > TB_MAX_STEP)  d = TB_MAX_STEP;
        if (d < -TB_MAX_STEP) d = -TB_MAX_STEP;
        m_out = m_out + d;
        m_we  = 1;
      end
      if (bus.en !== 1'b1) begin
        m_target = 0;
      end else if (bus.code_valid === 1'b1 && m_ready == 1) begin
        c = int'($signed(bus.code_in));
        if (c > TB_CODE_MAX) c = TB_CODE_MAX;
        if (c < TB_CODE_MIN) c = TB_CODE_MIN;
        m_target = c;
      end
      m_ready = (bus.en === 1'b1) ? 1 : 0;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; bus.en = 1'b0; bus.code_valid = 1'b0; bus.code_in = '0;
    repeat (3) clk_step();
    rst_n = 1'b1; bus.en = 1'b1;
    clk_step();
  endtask

  task automatic accept_code(input int c);
    bus.code_valid = 1'b1;
    bus.code_in    = dac_code_t'(c);
    clk_step();
    bus.code_valid = 1'b0;
  endtask

  task automatic run_until_settled(input int limit);
    int last_cyc;
    strobes.delete();
    gaps_ok = 1; settle_ok = 1; timed_out = 1; last_cyc = -1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      clk_step();
      if (bus.dac_we === 1'b1) begin
        strobes.push_back(dac_val());
        if (last_cyc >= 0 && (cyc - last_cyc) != TB_TICK_DIV) gaps_ok = 0;
        last_cyc = cyc;
      end
      if (bus.settled === 1'b1) begin
        if (bus.dac_we !== 1'b1) settle_ok = 0;
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.code_valid = 1'b0; bus.code_in = '0;
    repeat (3) clk_step();
    n_checks++;
    if (bus.dac_data !== RST_RAW) $display("FAIL reset_dac_data: got %h, expected %h", bus.dac_data, RST_RAW);
    else n_pass++;
    n_checks++;
    if (bus.dac_we !== 1'b0) $display("FAIL reset_dac_we: got %b, expected 0", bus.dac_we);
    else n_pass++;
    n_checks++;
    if (bus.settled !== 1'b1) $display("FAIL reset_settled: got %b, expected 1", bus.settled);
    else n_pass++;
    n_checks++;
    if (bus.code_ready !== 1'b0) $display("FAIL reset_code_ready: got %b, expected 0", bus.code_ready);
    else n_pass++;
    rst_n = 1'b1; bus.en = 1'b1;
    #1;
    n_checks++;
    if (bus.code_ready !== 1'b0) $display("FAIL ready_latency_before_edge: got %b, expected 0", bus.code_ready);
    else n_pass++;
    clk_step();
    n_checks++;
    if (bus.code_ready !== 1'b1) $display("FAIL ready_after_en: got %b, expected 1", bus.code_ready);
    else n_pass++;
  endtask

  task automatic test_ramp_up();
    int exp_seq[4] = '{64, 128, 192, 200};
    int got;
    reset_dut();
    accept_code(200);
    n_checks++;
    if (bus.settled !== 1'b0) $display("FAIL up_settled_drop: got %b, expected 0", bus.settled);
    else n_pass++;
    run_until_settled(40);
    n_checks++;
    if (timed_out) $display("FAIL up_timeout: got timeout, expected settle within 40 cycles");
    else n_pass++;
    n_checks++;
    if (strobes.size() != 4) $display("FAIL up_strobe_count: got %0d, expected 4", strobes.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < strobes.size()) ? strobes[i] : 99999;
      n_checks++;
      if (got != exp_seq[i]) $display("FAIL up_step%0d: got %0d, expected %0d", i, got, exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (!gaps_ok) $display("FAIL up_tick_spacing: got irregular gaps, expected %0d cycles", TB_TICK_DIV);
    else n_pass++;
    n_checks++;
    if (!settle_ok) $display("FAIL up_settled_with_strobe: got 0, expected 1");
    else n_pass++;
  endtask

  task automatic test_ramp_down();
    int exp_seq[2] = '{-64, -100};
    int got;
    bit we_seen, unsettled;
    reset_dut();
    accept_code(-100);
    run_until_settled(40);
    n_checks++;
    if (strobes.size() != 2) $display("FAIL down_strobe_count: got %0d, expected 2", strobes.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < strobes.size()) ? strobes[i] : 99999;
      n_checks++;
      if (got != exp_seq[i]) $display("FAIL down_step%0d: got %0d, expected %0d", i, got, exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (!settle_ok || timed_out) $display("FAIL down_settle: got %b, expected 1", settle_ok && !timed_out);
    else n_pass++;
    we_seen = 0; unsettled = 0;
    accept_code(-100);
    if (bus.settled !== 1'b1) unsettled = 1;
    if (bus.dac_we === 1'b1) we_seen = 1;
    repeat (3 * TB_TICK_DIV) begin
      clk_step();
      if (bus.dac_we === 1'b1) we_seen = 1;
      if (bus.settled !== 1'b1) unsettled = 1;
    end
    n_checks++;
    if (we_seen) $display("FAIL same_target_we: got strobe, expected none");
    else n_pass++;
    n_checks++;
    if (unsettled) $display("FAIL same_target_settled: got 0, expected 1");
    else n_pass++;
  endtask

  task automatic test_retarget();
    int exp_seq[2] = '{64, 0};
    int got;
    bit found;
    reset_dut();
    accept_code(1000);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      clk_step();
      if (bus.dac_we === 1'b1 && dac_val() == 128) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL retarget_reach128: got timeout, expected dac_data 128");
    else n_pass++;
    accept_code(0);
    run_until_settled(40);
    n_checks++;
    if (strobes.size() != 2) $display("FAIL retarget_strobe_count: got %0d, expected 2", strobes.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < strobes.size()) ? strobes[i] : 99999;
      n_checks++;
      if (got != exp_seq[i]) $display("FAIL retarget_step%0d: got %0d, expected %0d", i, got, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    int exp_seq[4] = '{136, 72, 8, 0};
    int got;
    reset_dut();
    accept_code(200);
    run_until_settled(40);
    bus.en = 1'b0;
    strobes.delete();
    for (int i = 0; i < 30; i++) begin
      bus.code_valid = 1'b1;
      bus.code_in    = dac_code_t'($urandom_range(0, 3000));
      clk_step();
      if (i == 0) begin
        n_checks++;
        if (bus.code_ready !== 1'b0) $display("FAIL disable_ready: got %b, expected 0", bus.code_ready);
        else n_pass++;
      end
      if (bus.dac_we === 1'b1) strobes.push_back(dac_val());
    end
    bus.code_valid = 1'b0;
    n_checks++;
    if (strobes.size() != 4) $display("FAIL disable_strobe_count: got %0d, expected 4", strobes.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < strobes.size()) ? strobes[i] : 99999;
      n_checks++;
      if (got != exp_seq[i]) $display("FAIL disable_step%0d: got %0d, expected %0d", i, got, exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (dac_val() != 0 || bus.settled !== 1'b1)
      $display("FAIL disable_final: got %0d/%b, expected 0/1", dac_val(), bus.settled);
    else n_pass++;
    bus.en = 1'b1;
    clk_step();
  endtask

  task automatic test_clamp();
    int peak;
    reset_dut();
    accept_code(8191);
    run_until_settled(400);
    peak = -100000;
    foreach (strobes[i]) if (strobes[i] > peak) peak = strobes[i];
    n_checks++;
    if (timed_out || dac_val() != TB_CODE_MAX)
      $display("FAIL clamp_high_final: got %0d, expected %0d", dac_val(), TB_CODE_MAX);
    else n_pass++;
    n_checks++;
    if (peak > TB_CODE_MAX) $display("FAIL clamp_high_peak: got %0d, expected <= %0d", peak, TB_CODE_MAX);
    else n_pass++;
    accept_code(-8192);
    run_until_settled(1000);
    n_checks++;
    if (timed_out || dac_val() != TB_CODE_MIN)
      $display("FAIL clamp_low_final: got %0d, expected %0d", dac_val(), TB_CODE_MIN);
    else n_pass++;
  endtask

  task automatic test_reset_midramp();
    reset_dut();
    accept_code(1000);
    repeat (9) clk_step();
    rst_n = 1'b0;
    clk_step();
    n_checks++;
    if (bus.dac_data !== RST_RAW || bus.dac_we !== 1'b0 || bus.settled !== 1'b1 || bus.code_ready !== 1'b0)
      $display("FAIL midramp_reset: got data=%h we=%b settled=%b ready=%b, expected %h/0/1/0",
               bus.dac_data, bus.dac_we, bus.settled, bus.code_ready, RST_RAW);
    else n_pass++;
    rst_n = 1'b1; bus.en = 1'b1;
    clk_step();
  endtask

  task automatic test_random();
    int sel, c;
    bit prev_we;
    reset_dut();
    prev_we = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.en         = ($urandom_range(0, 19) != 0);
      bus.code_valid = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      if (sel < 2)       c = int'($signed(14'($urandom)));
      else if (sel == 2) c = m_out + $urandom_range(0, 200) - 100;
      else               c = m_out;
      bus.code_in = dac_code_t'(c);
      clk_step();
      n_checks++;
      if (dac_val() != m_out) $display("FAIL rand_data@%0d: got %0d, expected %0d", i, dac_val(), m_out);
      else n_pass++;
      n_checks++;
      if (bus.dac_we !== m_we[0]) $display("FAIL rand_we@%0d: got %b, expected %0d", i, bus.dac_we, m_we);
      else n_pass++;
      n_checks++;
      if (bus.settled !== (m_out == m_target)) $display("FAIL rand_settled@%0d: got %b, expected %0d", i, bus.settled, m_out == m_target);
      else n_pass++;
      n_checks++;
      if (bus.code_ready !== m_ready[0]) $display("FAIL rand_ready@%0d: got %b, expected %0d", i, bus.code_ready, m_ready);
      else n_pass++;
      n_checks++;
      if (prev_we && bus.dac_we === 1'b1) $display("FAIL rand_we_back_to_back@%0d: got 1, expected 0", i);
      else n_pass++;
      prev_we = (bus.dac_we === 1'b1);
    end
    bus.code_valid = 1'b0;
    bus.en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en = 1'b0; bus.code_valid = 1'b0; bus.code_in = '0;
    m_target = 0; m_out = 0; m_cnt = 0; m_ready = 0; m_we = 0;
    #1;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_retarget();
    test_disable();
    test_clamp();
    test_reset_midramp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
